any1_issue_scheduler: RTL

- Multi-port successor to the single-issue ANY-1 instruction scheduler. Sits between the reorder buffer and NCHAN execution channels.
- Each cycle it wakes up every ready ROB entry, then selects up to one entry per channel, oldest first with branch priority.
- Each pick is presented through a registered valid/ready handshake. Recently issued slots are suppressed until the ROB "out" flag catches up.

---
 rtl/any1_issue_scheduler_if.sv | 16 +
 rtl/any1_issue_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/any1_issue_scheduler_if.sv
// Issue bus between the scheduler and its execution channels.
//   iss_valid  per-channel issue valid (scheduler -> channel)
//   iss_rid    per-channel ROB slot index, channel c at [c*RID_W +: RID_W]
//   iss_ready  per-channel accept (channel -> scheduler)
// master = scheduler side, slave = channel side.
interface any1_issue_scheduler_if #(
    parameter int unsigned NCHAN = 2,
    parameter int unsigned RID_W = 6
);
    logic [NCHAN-1:0]       iss_valid;
    logic [NCHAN*RID_W-1:0] iss_rid;
    logic [NCHAN-1:0]       iss_ready;

    modport master (output iss_valid, output iss_rid, input iss_ready);
    modport slave  (input iss_valid, input iss_rid, output iss_ready);
endinterface

// File: rtl/any1_issue_scheduler.sv
// Multi-channel ANY-1 issue scheduler: wakes up ready ROB slots and picks up
// to one slot per channel each cycle (oldest first, branches preferred),
// presenting each pick on a registered valid/ready handshake.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous clear of issue registers, history, counters
//   rob_head          oldest ROB slot; age(i) = (i - rob_head) mod ROB_ENTRIES
//   ent_*             per-slot ROB status; ent_chan bit i*NCHAN+c = slot i runs on channel c
//   wakeup_list       combinational eligible vector
//   iss               issue bus (master side)
// Optional feature: define ANY1_SCHED_STARVE_GUARD_EN to bound consecutive
// branch-priority picks per channel to STARVE_MAX.
module any1_issue_scheduler #(
    parameter int unsigned ROB_ENTRIES = 64,
    parameter int unsigned NCHAN       = 2,
    parameter int unsigned HIST        = 3,
`ifdef ANY1_SCHED_STARVE_GUARD_EN
    parameter int unsigned STARVE_MAX  = 15,
`endif
    localparam int unsigned RID_W      = $clog2(ROB_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [RID_W-1:0]             rob_head,
    input  logic [ROB_ENTRIES-1:0]       ent_v,
    input  logic [ROB_ENTRIES-1:0]       ent_dec,
    input  logic [ROB_ENTRIES-1:0]       ent_cmt,
    input  logic [ROB_ENTRIES-1:0]       ent_out,
    input  logic [ROB_ENTRIES-1:0]       ent_argv,
    input  logic [ROB_ENTRIES-1:0]       ent_mem,
    input  logic [ROB_ENTRIES-1:0]       ent_fc,
    input  logic [ROB_ENTRIES-1:0]       ent_br,
    input  logic [ROB_ENTRIES*NCHAN-1:0] ent_chan,
    output logic [ROB_ENTRIES-1:0]       wakeup_list,
    any1_issue_scheduler_if.master       iss
);
    logic [NCHAN-1:0]       vld_q;
    logic [RID_W-1:0]       rid_q [NCHAN];
    logic [HIST-1:0]        hv_q  [NCHAN];
    logic [RID_W-1:0]       hr_q  [NCHAN][HIST];

    logic [ROB_ENTRIES-1:0] supp_c;
    logic [ROB_ENTRIES-1:0] elig_a_c;     // eligibility in age order
    logic [ROB_ENTRIES-1:0] br_a_c;
    logic [ROB_ENTRIES-1:0] chan_a_c [NCHAN];
    logic [RID_W-1:0]       idx_c;
    logic                   rdy_c, fc_seen_c, mem_seen_c;

    logic [NCHAN-1:0]       load_c, pick_v_c, force_c;
    logic [RID_W-1:0]       pick_k_c [NCHAN]; // age of the pick
    logic [ROB_ENTRIES-1:0] taken_c, cand_c;
    logic                   ofound_c, bfound_c;
    logic [RID_W-1:0]       ok_c, bk_c;
`ifdef ANY1_SCHED_STARVE_GUARD_EN
    logic [NCHAN-1:0]       pick_old_c;
`endif

    assign load_c = ~vld_q | iss.iss_ready;

    // Slots held on a channel or still in issue history are suppressed.
    always_comb begin
        supp_c = '0;
        for (int c = 0; c < int'(NCHAN); c++) begin
            if (vld_q[c]) supp_c[rid_q[c]] = 1'b1;
            for (int h = 0; h < int'(HIST); h++)
                if (hv_q[c][h]) supp_c[hr_q[c][h]] = 1'b1;
        end
    end

    // Wakeup: walk slots oldest to youngest, accumulating fc/mem blockers.
    always_comb begin
        elig_a_c    = '0;
        br_a_c      = '0;
        wakeup_list = '0;
        idx_c       = '0;
        rdy_c       = 1'b0;
        fc_seen_c   = 1'b0;
        mem_seen_c  = 1'b0;
        for (int c = 0; c < int'(NCHAN); c++) chan_a_c[c] = '0;
        for (int k = 0; k < int'(ROB_ENTRIES); k++) begin
            idx_c = rob_head + RID_W'(k);
            rdy_c = ent_v[idx_c] & ent_dec[idx_c] & ent_argv[idx_c] &
                    ~ent_cmt[idx_c] & ~ent_out[idx_c] & ~supp_c[idx_c];
            elig_a_c[k]        = rdy_c & ~fc_seen_c & ~(ent_mem[idx_c] & mem_seen_c);
            wakeup_list[idx_c] = elig_a_c[k];
            br_a_c[k]          = ent_br[idx_c];
            for (int c = 0; c < int'(NCHAN); c++)
                chan_a_c[c][k] = ent_chan[int'(idx_c) * int'(NCHAN) + c];
            fc_seen_c  = fc_seen_c  | (ent_v[idx_c] & ~ent_cmt[idx_c] & ent_fc[idx_c]);
            mem_seen_c = mem_seen_c | (ent_v[idx_c] & ent_mem[idx_c] & ~ent_cmt[idx_c] &
                                       ~ent_out[idx_c] & ~supp_c[idx_c]);
        end
    end

    // Select per channel in channel order; a held channel makes no pick.
    always_comb begin
        taken_c  = '0;
        cand_c   = '0;
        pick_v_c = '0;
        ofound_c = 1'b0;
        bfound_c = 1'b0;
        ok_c     = '0;
        bk_c     = '0;
`ifdef ANY1_SCHED_STARVE_GUARD_EN
        pick_old_c = '0;
`endif
        for (int c = 0; c < int'(NCHAN); c++) begin
            pick_k_c[c] = '0;
            cand_c   = elig_a_c & chan_a_c[c] & ~taken_c;
            ofound_c = 1'b0;
            bfound_c = 1'b0;
            ok_c     = '0;
            bk_c     = '0;
            for (int k = 0; k < int'(ROB_ENTRIES); k++) begin
                if (cand_c[k] && !ofound_c) begin
                    ofound_c = 1'b1;
                    ok_c     = RID_W'(k);
                end
                if (cand_c[k] && br_a_c[k] && !bfound_c) begin
                    bfound_c = 1'b1;
                    bk_c     = RID_W'(k);
                end
            end
            if (load_c[c] && ofound_c) begin
                pick_v_c[c] = 1'b1;
                pick_k_c[c] = (bfound_c && !force_c[c]) ? bk_c : ok_c;
                taken_c[pick_k_c[c]] = 1'b1;
`ifdef ANY1_SCHED_STARVE_GUARD_EN
                pick_old_c[c] = (pick_k_c[c] == ok_c);
`endif
            end
        end
    end

`ifdef ANY1_SCHED_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] cnt_q [NCHAN];

    always_comb begin
        for (int c = 0; c < int'(NCHAN); c++)
            force_c[c] = (cnt_q[c] == CNT_W'(STARVE_MAX));
    end

    // Count branch picks that bypassed the oldest candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(NCHAN); c++) cnt_q[c] <= '0;
        end else if (flush) begin
            for (int c = 0; c < int'(NCHAN); c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < int'(NCHAN); c++)
                if (pick_v_c[c])
                    cnt_q[c] <= pick_old_c[c] ? '0 : cnt_q[c] + CNT_W'(1);
        end
    end
`else
    assign force_c = '0;
`endif

    // Issue registers and per-channel accept history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int c = 0; c < int'(NCHAN); c++) begin
                rid_q[c] <= '0;
                hv_q[c]  <= '0;
                for (int h = 0; h < int'(HIST); h++) hr_q[c][h] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
            for (int c = 0; c < int'(NCHAN); c++) hv_q[c] <= '0;
        end else begin
            for (int c = 0; c < int'(NCHAN); c++) begin
                for (int h = int'(HIST) - 1; h > 0; h--) begin
                    hv_q[c][h] <= hv_q[c][h-1];
                    hr_q[c][h] <= hr_q[c][h-1];
                end
                hv_q[c][0] <= vld_q[c] & iss.iss_ready[c];
                hr_q[c][0] <= rid_q[c];
                if (load_c[c]) begin
                    vld_q[c] <= pick_v_c[c];
                    if (pick_v_c[c]) rid_q[c] <= rob_head + pick_k_c[c];
                end
            end
        end
    end

    assign iss.iss_valid = vld_q;
    for (genvar g = 0; g < int'(NCHAN); g++) begin : g_rid
        assign iss.iss_rid[g*RID_W +: RID_W] = rid_q[g];
    end
endmodule
